// File: rtl/cbus_axi_bridge.sv
// cbus_axi_bridge: one-outstanding cache-bus request to a single AXI3 master port.
// Reads walk AR/R and return each beat; writes issue AW and W concurrently and
// then wait for B. A watchdog aborts a transfer that stalls with no handshakes.
module cbus_axi_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int AXI_ID     = 0,
    parameter int BURST_TYPE = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // cache-bus request
    input  logic                    creq_valid,
    input  logic                    creq_is_write,
    input  logic [31:0]             creq_addr,
    input  logic [2:0]              creq_size,
    input  logic [3:0]              creq_len,
    input  logic [DATA_WIDTH-1:0]   creq_data,
    input  logic [DATA_WIDTH/8-1:0] creq_strobe,
    // cache-bus response
    output logic                    cresp_ready,
    output logic                    cresp_last,
    output logic [DATA_WIDTH-1:0]   cresp_data,
    output logic                    cresp_error,
    // AR channel
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    // R channel
    input  logic [3:0]              rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    // AW channel
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    // W channel
    output logic [3:0]              wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    // B channel
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    // Watchdog counter sized to hold TIMEOUT; a TIMEOUT of 0 disables it.
    localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic            WD_EN    = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic                  cresp_ready_s;
    logic                  cresp_last_s;
    logic                  cresp_error_s;
    logic [DATA_WIDTH-1:0] cresp_data_s;

    logic ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s, any_hs_s;
    logic cnt_zero_s, wdog_fire_s;

    // IDs are constant per bridge, so returned IDs carry no information here.
    logic unused_ids_s;
    assign unused_ids_s = ^{rid, bid};

    assign ar_hs_s    = arvalid_q & arready;
    assign r_hs_s     = rready_q & rvalid;
    assign aw_hs_s    = awvalid_q & awready;
    assign w_hs_s     = wvalid_q & wready;
    assign b_hs_s     = bready_q & bvalid;
    assign any_hs_s   = ar_hs_s | r_hs_s | aw_hs_s | w_hs_s | b_hs_s;
    assign cnt_zero_s = (cnt_q == 4'd0);
    assign wdog_fire_s = WD_EN && (state_q != ST_IDLE) && !any_hs_s && (wdog_q == WD_LIMIT);

    // Next-state, channel control and cache-bus response generation.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        wdog_d        = wdog_q;
        cresp_ready_s = 1'b0;
        cresp_last_s  = 1'b0;
        cresp_error_s = 1'b0;
        cresp_data_s  = '0;

        case (state_q)
            ST_IDLE: begin
                err_d     = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (creq_valid) begin
                    addr_d = creq_addr;
                    size_d = creq_size;
                    len_d  = creq_len;
                    cnt_d  = creq_len;
                    if (creq_is_write) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD: begin
                if (ar_hs_s) begin
                    arvalid_d = 1'b0;
                end else begin
                    arvalid_d = arvalid_q;
                end
                // Beats are forwarded even before AR completes; the local counter,
                // not rlast, decides which beat is the final one.
                if (r_hs_s) begin
                    cresp_ready_s = 1'b1;
                    cresp_data_s  = rdata;
                    if ((rresp != 2'd0) || (rlast != cnt_zero_s)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (cnt_zero_s) begin
                        cresp_last_s  = 1'b1;
                        cresp_error_s = err_q | (rresp != 2'd0) | ~rlast;
                        state_d       = ST_IDLE;
                        arvalid_d     = 1'b0;
                        rready_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_WR: begin
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (w_hs_s) begin
                    cresp_ready_s = 1'b1;
                    if (cnt_zero_s) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                // B is only accepted once both address and all data are out.
                if (b_hs_s) begin
                    cresp_ready_s = 1'b1;
                    cresp_last_s  = 1'b1;
                    cresp_error_s = err_q | (bresp != 2'd0);
                    bready_d      = 1'b0;
                    state_d       = ST_IDLE;
                end else if ((aw_done_q | aw_hs_s) && (w_done_q | (w_hs_s & cnt_zero_s))) begin
                    bready_d = 1'b1;
                end else begin
                    bready_d = bready_q;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase

        // Watchdog: abort with an error completion after a stall of TIMEOUT cycles.
        if (wdog_fire_s) begin
            cresp_ready_s = 1'b1;
            cresp_last_s  = 1'b1;
            cresp_error_s = 1'b1;
            cresp_data_s  = '0;
            state_d       = ST_IDLE;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            wdog_d        = '0;
        end else if (WD_EN && (state_q != ST_IDLE) && !any_hs_s) begin
            wdog_d = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wdog_d = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            size_q    <= 3'd0;
            len_q     <= 4'd0;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wdog_q    <= wdog_d;
        end
    end

    // Cache-bus response follows the current handshake so read data passes through.
    assign cresp_ready = cresp_ready_s;
    assign cresp_last  = cresp_last_s;
    assign cresp_error = cresp_error_s;
    assign cresp_data  = cresp_data_s;

    assign arid    = 4'(AXI_ID);
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = 2'(BURST_TYPE);
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = 4'(AXI_ID);
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = size_q;
    assign awburst = 2'(BURST_TYPE);
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;

    assign wid     = 4'(AXI_ID);
    assign wdata   = creq_data;
    assign wstrb   = creq_strobe;
    assign wlast   = cnt_zero_s;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Directed bench for cbus_axi_bridge with a response scoreboard.
module tb_cbus_axi_bridge;

    localparam int DW = 64;

    logic          aclk, aresetn;
    logic          creq_valid, creq_is_write;
    logic [31:0]   creq_addr;
    logic [2:0]    creq_size;
    logic [3:0]    creq_len;
    logic [DW-1:0] creq_data;
    logic [7:0]    creq_strobe;
    logic          cresp_ready, cresp_last, cresp_error;
    logic [DW-1:0] cresp_data;
    logic [3:0]    arid, arlen, arcache, awid, awlen, awcache, wid, rid, bid;
    logic [31:0]   araddr, awaddr;
    logic [2:0]    arsize, arprot, awsize, awprot;
    logic [1:0]    arburst, arlock, awburst, awlock, rresp, bresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0] rdata, wdata;
    logic [7:0]    wstrb;

    cbus_axi_bridge #(.DATA_WIDTH(64), .AXI_ID(5), .BURST_TYPE(1), .TIMEOUT(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
        .creq_size(creq_size), .creq_len(creq_len), .creq_data(creq_data),
        .creq_strobe(creq_strobe),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
        .cresp_error(cresp_error),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [63:0] d, input logic l, input logic e, input logic cd);
        exp_t x;
        x.data = d; x.last = l; x.err = e; x.chk_data = cd;
        sb.push_back(x);
    endtask

    // Monitor: every cache-bus response beat is compared against the scoreboard.
    always @(negedge aclk) begin
        if (aresetn && cresp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got last=%0b err=%0b expected no response",
                         cresp_last, cresp_error);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("resp_last", 64'(cresp_last), 64'(x.last));
                chk("resp_error", 64'(cresp_error), 64'(x.err));
                if (x.chk_data) chk("resp_data", cresp_data, x.data);
            end
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] len,
                         input logic [63:0] d);
        creq_valid    = 1'b1;
        creq_is_write = wr;
        creq_addr     = a;
        creq_size     = 3'd3;
        creq_len      = len;
        creq_data     = d;
        creq_strobe   = 8'hFF;
        cyc();
        creq_valid    = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] d, input logic [1:0] resp, input logic l);
        rvalid = 1'b1; rdata = d; rresp = resp; rlast = l;
        cyc();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
    endtask

    task automatic ar_hs();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        aresetn = 1'b0; creq_valid = 1'b0; creq_is_write = 1'b0; creq_addr = 32'd0;
        creq_size = 3'd0; creq_len = 4'd0; creq_data = 64'd0; creq_strobe = 8'd0;
        arready = 1'b0; rid = 4'd5; rdata = 64'd0; rresp = 2'd0; rlast = 1'b0;
        rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = 4'd5; bresp = 2'd0;
        bvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_valids", {59'd0, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
        chk("rst_cresp", {61'd0, cresp_ready, cresp_last, cresp_error}, 64'd0);
        aresetn = 1'b1;
        cyc();

        // Read len=3 with gaps between R beats.
        for (int i = 0; i < 4; i++) expect_resp(64'hA0 + 64'(i), i == 3, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_1000, 4'd3, 64'd0);
        chk("rd_arvalid", 64'(arvalid), 64'd1);
        chk("rd_rready", 64'(rready), 64'd1);
        chk("rd_arlen", 64'(arlen), 64'd3);
        chk("rd_arburst", 64'(arburst), 64'd1);
        chk("rd_araddr", 64'(araddr), 64'h1000);
        chk("rd_arid", 64'(arid), 64'd5);
        chk("rd_arsize", 64'(arsize), 64'd3);
        chk("rd_awvalid", 64'(awvalid), 64'd0);
        ar_hs();
        chk("rd_arvalid_drop", 64'(arvalid), 64'd0);
        r_beat(64'hA0, 2'd0, 1'b0);
        cyc();
        r_beat(64'hA1, 2'd0, 1'b0);
        cyc(); cyc();
        r_beat(64'hA2, 2'd0, 1'b0);
        r_beat(64'hA3, 2'd0, 1'b1);
        chk("rd_done_rready", 64'(rready), 64'd0);
        cyc();

        // Write len=1: AW immediate, W delayed 3 cycles, OKAY response.
        expect_resp(64'd0, 1'b0, 1'b0, 1'b0);
        expect_resp(64'd0, 1'b0, 1'b0, 1'b0);
        expect_resp(64'd0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 32'h0000_2000, 4'd1, 64'hD0);
        chk("wr_awvalid", 64'(awvalid), 64'd1);
        chk("wr_wvalid", 64'(wvalid), 64'd1);
        chk("wr_awlen", 64'(awlen), 64'd1);
        chk("wr_awaddr", 64'(awaddr), 64'h2000);
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        chk("wr_awvalid_drop", 64'(awvalid), 64'd0);
        chk("wr_bready_early", 64'(bready), 64'd0);
        cyc(); cyc();
        wready = 1'b1;
        chk("wr_wlast_b0", 64'(wlast), 64'd0);
        chk("wr_wdata_b0", wdata, 64'hD0);
        cyc();
        creq_data = 64'hD1;
        chk("wr_wlast_b1", 64'(wlast), 64'd1);
        chk("wr_wdata_b1", wdata, 64'hD1);
        chk("wr_bready_mid", 64'(bready), 64'd0);
        cyc();
        wready = 1'b0;
        chk("wr_wvalid_drop", 64'(wvalid), 64'd0);
        chk("wr_bready", 64'(bready), 64'd1);
        bvalid = 1'b1; bresp = 2'd0;
        cyc();
        bvalid = 1'b0;
        chk("wr_bready_drop", 64'(bready), 64'd0);
        cyc();

        // Read len=0 with SLVERR; AR and R in the same cycle.
        expect_resp(64'hC5, 1'b1, 1'b1, 1'b1);
        issue(1'b0, 32'h0000_3000, 4'd0, 64'd0);
        arready = 1'b1;
        r_beat(64'hC5, 2'd2, 1'b1);
        arready = 1'b0;
        chk("slverr_arvalid", 64'(arvalid), 64'd0);
        cyc();

        // Read len=3 with rlast on beat 2: completion on the counter, flagged as error.
        for (int i = 0; i < 4; i++) expect_resp(64'hB0 + 64'(i), i == 3, i == 3, 1'b1);
        issue(1'b0, 32'h0000_3100, 4'd3, 64'd0);
        ar_hs();
        r_beat(64'hB0, 2'd0, 1'b0);
        r_beat(64'hB1, 2'd0, 1'b1);
        r_beat(64'hB2, 2'd0, 1'b0);
        r_beat(64'hB3, 2'd0, 1'b0);
        chk("early_rlast_rready", 64'(rready), 64'd0);
        cyc();

        // Watchdog: write with AW and W stalled.
        expect_resp(64'd0, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 32'h0000_4000, 4'd0, 64'hEE);
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            chk("wdog_pulse", 64'(cresp_ready), 64'(k == 8));
        end
        cyc();
        chk("wdog_awvalid", 64'(awvalid), 64'd0);
        chk("wdog_wvalid", 64'(wvalid), 64'd0);
        awready = 1'b1; bvalid = 1'b1; bresp = 2'd0;
        cyc();
        awready = 1'b0; bvalid = 1'b0;
        expect_resp(64'hC0, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_4100, 4'd0, 64'd0);
        ar_hs();
        r_beat(64'hC0, 2'd0, 1'b1);
        cyc();

        // Asynchronous reset during read beat 2.
        expect_resp(64'hD0, 1'b0, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_5000, 4'd3, 64'd0);
        ar_hs();
        r_beat(64'hD0, 2'd0, 1'b0);
        rvalid = 1'b1; rdata = 64'hD1;
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_cresp_ready", 64'(cresp_ready), 64'd0);
        chk("arst_rready", 64'(rready), 64'd0);
        chk("arst_arvalid", 64'(arvalid), 64'd0);
        rvalid = 1'b0;
        cyc(); cyc();
        aresetn = 1'b1;
        cyc();
        chk("arst_idle_valids", {59'd0, arvalid, awvalid, wvalid, rready, bready}, 64'd0);
        expect_resp(64'hE0, 1'b0, 1'b0, 1'b1);
        expect_resp(64'hE1, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 32'h0000_6000, 4'd1, 64'd0);
        chk("arst_new_araddr", 64'(araddr), 64'h6000);
        ar_hs();
        r_beat(64'hE0, 2'd0, 1'b0);
        r_beat(64'hE1, 2'd0, 1'b1);
        cyc(); cyc();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
